// File: rtl/rede_pkg.sv
// Shared definitions for the Taylor-network output path.
// Provides the result width, output port count, channel tag width, default
// buffer sizing, the buffered entry type and the strobe-to-channel decoder.
package rede_pkg;

  localparam int DW         = 28;  // signed result width (float2int output)
  localparam int NCH        = 4;   // number of core output ports
  localparam int CW         = 2;   // channel tag width, clog2(NCH)
  localparam int FIFO_DEPTH = 16;  // default collector buffer depth
  localparam int CNT_W      = 16;  // default drop counter width

  // One buffered result: channel tag in the upper bits, raw data below.
  typedef struct packed {
    logic [CW-1:0]        chan;
    logic signed [DW-1:0] data;
  } out_entry_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [CW-1:0] lowest_set(input logic [NCH-1:0] v);
    logic [CW-1:0] idx;
    idx = {CW{1'b0}};
    // Walk downwards so the lowest set bit is the last one to win.
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = v[i] ? CW'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a registered first-word-fall-through head.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   wr_en, wr_data write request and data (ignored when full without a read)
//   rd_en          consumer takes the head (ignored when empty)
//   rd_data        registered head entry, held stable until it is read
//   rd_valid       head entry is valid
//   level          occupancy 0..DEPTH
// Storage is not reset; only pointers, level and the head register are.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic [WIDTH-1:0] head_r;
  logic             valid_r;

  logic             wr_s;
  logic             rd_s;
  logic [AW-1:0]    rd_ptr_p1_s;
  logic [LW-1:0]    level_nxt_s;
  logic [WIDTH-1:0] head_nxt_s;

  // Qualify requests, compute next occupancy and the next head entry.
  always_comb begin
    rd_s        = rd_en & valid_r;
    wr_s        = wr_en & ((level_r != LW'(DEPTH)) | rd_s);
    rd_ptr_p1_s = rd_ptr_r + AW'(1);
    level_nxt_s = level_r;
    head_nxt_s  = head_r;

    case ({wr_s, rd_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase

    // The head register always mirrors the oldest stored entry. After a read
    // the next entry comes from storage, or straight from the write port when
    // the read empties storage in the same cycle as a write.
    if (rd_s) begin
      if (level_r >= LW'(2)) begin
        head_nxt_s = mem_r[rd_ptr_p1_s];
      end else if (wr_s) begin
        head_nxt_s = wr_data;
      end else begin
        head_nxt_s = head_r;
      end
    end else if (wr_s && (level_r == LW'(0))) begin
      head_nxt_s = wr_data;
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Storage array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      head_r   <= {WIDTH{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_p1_s;
      end
      level_r <= level_nxt_s;
      head_r  <= head_nxt_s;
      valid_r <= (level_nxt_s != LW'(0));
    end
  end

  assign rd_data  = head_r;
  assign rd_valid = valid_r;
  assign level    = level_r;

endmodule

// File: rtl/taylor_out_collector.sv
// Collects results written by the Taylor-network core and streams them out.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   io_out     signed result from the core
//   out_en     one-hot port write strobe; each high cycle is one write
//   m_valid, m_ready, m_data, m_chan
//              valid/ready stream of {channel, data}, head of the buffer
//   level      buffer occupancy 0..DEPTH
//   ovf        sticky: a result was discarded because the buffer was full
//   drop_cnt   saturating count of discarded results
//   err_mh     sticky: out_en was seen with more than one bit set
//   clr        synchronous clear of ovf, drop_cnt and err_mh
module taylor_out_collector
  import rede_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CNTW  = CNT_W,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] io_out,
  input  logic [NCH-1:0]       out_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] m_data,
  output logic [CW-1:0]        m_chan,
  output logic [LW-1:0]        level,
  output logic                 ovf,
  output logic [CNTW-1:0]      drop_cnt,
  output logic                 err_mh,
  input  logic                 clr
);

  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            drop_s;
  logic            wr_s;
  logic            mh_s;
  out_entry_t      wr_entry_s;
  out_entry_t      head_s;
  logic [LW-1:0]   level_s;

  logic            ovf_r;
  logic            err_mh_r;
  logic [CNTW-1:0] drop_cnt_r;
  logic            ovf_nxt_s;
  logic            err_mh_nxt_s;
  logic [CNTW-1:0] drop_cnt_nxt_s;

  // Strobe decode, drop decision and sticky flag next-state.
  always_comb begin
    push_s           = |out_en;
    // Clearing the lowest set bit leaves something only if more than one was set.
    mh_s             = (out_en & (out_en - NCH'(1))) != {NCH{1'b0}};
    pop_s            = m_valid & m_ready;
    full_s           = (level_s == LW'(DEPTH));
    // A simultaneous pop frees a slot, so full only drops without one.
    drop_s           = push_s & full_s & ~pop_s;
    wr_s             = push_s & ~drop_s;
    wr_entry_s.chan  = lowest_set(out_en);
    wr_entry_s.data  = io_out;

    ovf_nxt_s      = ovf_r;
    err_mh_nxt_s   = err_mh_r;
    drop_cnt_nxt_s = drop_cnt_r;

    // A same-cycle event overrides the clear.
    if (clr) begin
      ovf_nxt_s      = drop_s;
      err_mh_nxt_s   = mh_s;
      drop_cnt_nxt_s = drop_s ? CNTW'(1) : {CNTW{1'b0}};
    end else begin
      ovf_nxt_s    = ovf_r | drop_s;
      err_mh_nxt_s = err_mh_r | mh_s;
      if (drop_s && (drop_cnt_r != {CNTW{1'b1}})) begin
        drop_cnt_nxt_s = drop_cnt_r + CNTW'(1);
      end else begin
        drop_cnt_nxt_s = drop_cnt_r;
      end
    end
  end

  // Sticky status flags and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r      <= 1'b0;
      err_mh_r   <= 1'b0;
      drop_cnt_r <= {CNTW{1'b0}};
    end else begin
      ovf_r      <= ovf_nxt_s;
      err_mh_r   <= err_mh_nxt_s;
      drop_cnt_r <= drop_cnt_nxt_s;
    end
  end

  sync_fifo #(
    .WIDTH($bits(out_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_s),
    .wr_data (wr_entry_s),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .rd_valid(m_valid),
    .level   (level_s)
  );

  assign m_data   = head_s.data;
  assign m_chan   = head_s.chan;
  assign level    = level_s;
  assign ovf      = ovf_r;
  assign drop_cnt = drop_cnt_r;
  assign err_mh   = err_mh_r;

endmodule

// File: tb/tb_taylor_out_collector.sv
// Scoreboard bench for taylor_out_collector: a reference model queues the
// expected stream entries and status; a negedge monitor compares them.
module tb_taylor_out_collector;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [1:0]         chan;
    logic signed [27:0] data;
  } exp_entry_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [27:0] io_out = '0;
  logic [3:0]         out_en = '0;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic signed [27:0] m_data;
  logic [1:0]         m_chan;
  logic [4:0]         level;
  logic               ovf;
  logic [15:0]        drop_cnt;
  logic               err_mh;
  logic               clr = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  exp_entry_t exp_q[$];
  int         mdl_level = 0;
  logic       mdl_ovf = 1'b0;
  int         mdl_cnt = 0;
  logic       mdl_err = 1'b0;

  taylor_out_collector dut (
    .clk(clk), .rst(rst), .io_out(io_out), .out_en(out_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan),
    .level(level), .ovf(ovf), .drop_cnt(drop_cnt), .err_mh(err_mh), .clr(clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic [3:0] en, input logic signed [27:0] d,
                      input logic rdy, input logic c);
    out_en  = en;
    io_out  = d;
    m_ready = rdy;
    clr     = c;
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain queue/count arithmetic on each clock edge.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        mdl_level = 0;
        mdl_ovf   = 1'b0;
        mdl_cnt   = 0;
        mdl_err   = 1'b0;
      end else begin
        bit         pop, push, drop, mh;
        exp_entry_t e;
        pop  = (mdl_level > 0) && m_ready;
        push = (out_en != 4'd0);
        mh   = ($countones(out_en) > 1);
        drop = push && (mdl_level == DEPTH) && !pop;
        if (push && !drop) begin
          e.chan = 2'd0;
          for (int i = 3; i >= 0; i--) if (out_en[i]) e.chan = 2'(i);
          e.data = io_out;
          exp_q.push_back(e);
        end
        mdl_level = mdl_level - (pop ? 1 : 0) + ((push && !drop) ? 1 : 0);
        if (clr) begin
          mdl_ovf = drop;
          mdl_cnt = drop ? 1 : 0;
          mdl_err = mh;
        end else begin
          mdl_ovf = mdl_ovf | drop;
          if (drop && mdl_cnt < 65535) mdl_cnt++;
          mdl_err = mdl_err | mh;
        end
      end
    end
  end

  // Monitor: status every cycle, stream entries on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("valid", 64'(m_valid), 64'(mdl_level != 0));
        check("level", 64'(level), 64'(mdl_level));
        check("ovf", 64'(ovf), 64'(mdl_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(mdl_cnt));
        check("err_mh", 64'(err_mh), 64'(mdl_err));
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(1), 64'(0));
          end else begin
            exp_entry_t e;
            e = exp_q.pop_front();
            check("chan", 64'(m_chan), 64'(e.chan));
            check("data", 64'(m_data), 64'(e.data));
          end
        end
      end
    end
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_level", 64'(level), 64'(0));
    check("rst_valid", 64'(m_valid), 64'(0));
    check("rst_data", 64'(m_data), 64'(0));
    check("rst_chan", 64'(m_chan), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    check("rst_cnt", 64'(drop_cnt), 64'(0));
    check("rst_err", 64'(err_mh), 64'(0));

    // 1: single entry, one cycle latency
    step(4'b0100, -28'sd5, 1'b1, 1'b0);
    check("t1_valid", 64'(m_valid), 64'(1));
    check("t1_chan", 64'(m_chan), 64'(2));
    check("t1_data", 64'(m_data), 64'(-28'sd5));
    step(4'b0000, 28'sd0, 1'b1, 1'b0);
    check("t1_empty", 64'(m_valid), 64'(0));
    check("t1_level", 64'(level), 64'(0));

    // 2: fill, then overflow
    for (int i = 0; i < 16; i++) step(4'b0010, 28'(i), 1'b0, 1'b0);
    check("t2_full", 64'(level), 64'(16));
    check("t2_noovf", 64'(ovf), 64'(0));
    step(4'b0010, 28'sd99, 1'b0, 1'b0);
    check("t2_ovf", 64'(ovf), 64'(1));
    check("t2_cnt", 64'(drop_cnt), 64'(1));
    check("t2_level", 64'(level), 64'(16));

    // 3: full with push and pop together
    step(4'b1000, 28'sd7, 1'b1, 1'b0);
    check("t3_level", 64'(level), 64'(16));
    check("t3_cnt", 64'(drop_cnt), 64'(1));
    for (int i = 0; i < 20; i++) step(4'b0000, 28'sd0, 1'b1, 1'b0);
    check("t3_drained", 64'(level), 64'(0));

    // 4: multi-hot strobe and clear
    step(4'b1010, 28'sd3, 1'b1, 1'b0);
    check("t4_err", 64'(err_mh), 64'(1));
    step(4'b0000, 28'sd0, 1'b1, 1'b1);
    check("t4_clr_err", 64'(err_mh), 64'(0));
    check("t4_clr_ovf", 64'(ovf), 64'(0));
    check("t4_clr_cnt", 64'(drop_cnt), 64'(0));

    // 5: saturate the drop counter, then clear with a simultaneous drop
    for (int i = 0; i < 16; i++) step(4'b0001, 28'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) step(4'b0001, 28'($urandom), 1'b0, 1'b0);
    check("t5_sat", 64'(drop_cnt), 64'(16'hFFFF));
    step(4'b0001, 28'sd1, 1'b0, 1'b1);
    check("t5_clr_cnt", 64'(drop_cnt), 64'(1));
    check("t5_clr_ovf", 64'(ovf), 64'(1));
    for (int i = 0; i < 20; i++) step(4'b0000, 28'sd0, 1'b1, 1'b0);

    // random traffic with varying back-pressure
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1000; i++) begin
        int          r;
        logic [3:0]  en;
        r  = $urandom_range(0, 9);
        if (r < 5) en = 4'd0;
        else if (r < 8) en = 4'(1 << $urandom_range(0, 3));
        else en = 4'($urandom_range(1, 15));
        step(en, 28'($urandom),
             (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
             $urandom_range(0, 63) == 0);
      end
    end
    for (int i = 0; i < 20; i++) step(4'b0000, 28'sd0, 1'b1, 1'b0);

    // 6: asynchronous reset with entries buffered
    for (int i = 0; i < 5; i++) step(4'b0001, 28'(100 + i), 1'b0, 1'b0);
    check("t6_five", 64'(level), 64'(5));
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", 64'(m_valid), 64'(0));
    check("t6_async_level", 64'(level), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(4'b1000, -28'sd1, 1'b1, 1'b0);
    check("t6_valid", 64'(m_valid), 64'(1));
    check("t6_chan", 64'(m_chan), 64'(3));
    check("t6_data", 64'(m_data), 64'(-28'sd1));
    step(4'b0000, 28'sd0, 1'b1, 1'b0);
    check("t6_single", 64'(m_valid), 64'(0));
    repeat (3) step(4'b0000, 28'sd0, 1'b1, 1'b0);

    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
